// File: rtl/matrix_op_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : matrix_op_sequencer_if
// Description : Bundles the command, datapath and write-back signals of the
//               matrix add/subtract sequencer.
//               master : command issuer plus the combinational datapath
//                        (drives start/opcode/operands, dp_result/dp_overflow)
//               slave  : the sequencer (drives dp_* operands, write port,
//                        busy/done/error/overflow_flag status)
// Revision    : 1.0 - initial release
// ============================================================================
interface matrix_op_sequencer_if #(
  parameter int ELEM_W    = 8,
  parameter int MAX_ELEMS = 25,
  parameter int ADDR_W    = 8
);
  localparam int MAT_W = ELEM_W * MAX_ELEMS;

  // Command side
  logic              start;
  logic [1:0]        opcode;
  logic [1:0]        matrix_size;
  logic [MAT_W-1:0]  matrix_A;
  logic [MAT_W-1:0]  matrix_B;
  logic [ADDR_W-1:0] dst_base;
  // Datapath side
  logic [MAT_W-1:0]  dp_matrix_A;
  logic [MAT_W-1:0]  dp_matrix_B;
  logic [1:0]        dp_size;
  logic [1:0]        dp_op_sel;
  logic [MAT_W-1:0]  dp_result;
  logic              dp_overflow;
  // Write-back port and status
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ELEM_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              overflow_flag;
  logic              error;

  modport master (
    output start, opcode, matrix_size, matrix_A, matrix_B, dst_base,
           dp_result, dp_overflow,
    input  dp_matrix_A, dp_matrix_B, dp_size, dp_op_sel,
           wr_en, wr_addr, wr_data, busy, done, overflow_flag, error
  );

  modport slave (
    input  start, opcode, matrix_size, matrix_A, matrix_B, dst_base,
           dp_result, dp_overflow,
    output dp_matrix_A, dp_matrix_B, dp_size, dp_op_sel,
           wr_en, wr_addr, wr_data, busy, done, overflow_flag, error
  );
endinterface
`default_nettype wire

// File: rtl/matrix_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : matrix_op_sequencer
// Description : Accepts one matrix ADD/SUB command, latches its operands,
//               lets the external combinational datapath settle for one
//               cycle, captures result and overflow, then writes the N active
//               elements to dst_base+idx, one per cycle, and pulses done.
//               Illegal opcodes pulse done+error without any write.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous active-high reset
//               bus   - matrix_op_sequencer_if.slave (command, datapath,
//                       write port, status)
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_op_sequencer #(
  parameter int ELEM_W    = 8,
  parameter int MAX_ELEMS = 25,
  parameter int ADDR_W    = 8
) (
  input wire                   clk,
  input wire                   reset,
  matrix_op_sequencer_if.slave bus
);
  localparam int MAT_W = ELEM_W * MAX_ELEMS;
  localparam int IDX_W = $clog2(MAX_ELEMS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  next_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [MAT_W-1:0]  result;
  logic [ADDR_W-1:0] base_addr;

  // Index of the final active element for each square size (N-1).
  function automatic logic [IDX_W-1:0] last_index(input logic [1:0] size);
    case (size)
      2'b00:   return IDX_W'(3);
      2'b01:   return IDX_W'(8);
      2'b10:   return IDX_W'(15);
      default: return IDX_W'(24);
    endcase
  endfunction

  assign last_idx = last_index(bus.dp_size);
  assign next_idx = idx + 1'b1;

  // wr_addr/wr_data are registered one element ahead: the value presented in
  // a WRITE cycle was prepared at the previous edge, so no input reaches an
  // output combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      result            <= '0;
      base_addr         <= '0;
      bus.dp_matrix_A   <= '0;
      bus.dp_matrix_B   <= '0;
      bus.dp_size       <= '0;
      bus.dp_op_sel     <= '0;
      bus.wr_en         <= 1'b0;
      bus.wr_addr       <= '0;
      bus.wr_data       <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.overflow_flag <= 1'b0;
      bus.error         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy          <= 1'b1;
            bus.overflow_flag <= 1'b0;
            if (bus.opcode[1]) begin
              bus.done  <= 1'b1;
              bus.error <= 1'b1;
              state     <= ERR;
            end else begin
              bus.dp_matrix_A <= bus.matrix_A;
              bus.dp_matrix_B <= bus.matrix_B;
              bus.dp_size     <= bus.matrix_size;
              base_addr       <= bus.dst_base;
              bus.dp_op_sel   <= bus.opcode[0] ? 2'b10 : 2'b01;
              state           <= EXEC;
            end
          end
        end
        EXEC: begin
          result            <= bus.dp_result;
          bus.overflow_flag <= bus.dp_overflow;
          bus.dp_op_sel     <= 2'b00;
          idx               <= '0;
          bus.wr_en         <= 1'b1;
          bus.wr_addr       <= base_addr;
          bus.wr_data       <= bus.dp_result[ELEM_W-1:0];
          state             <= WRITE;
        end
        WRITE: begin
          if (idx == last_idx) begin
            // Address/data stay at the last element while wr_en is low.
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b1;
            state     <= DONE;
          end else begin
            idx         <= next_idx;
            bus.wr_addr <= bus.wr_addr + 1'b1;
            bus.wr_data <= result[ELEM_W*int'(next_idx) +: ELEM_W];
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          bus.done  <= 1'b0;
          bus.error <= 1'b0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
Command sequencer for the coprocessor's combinational matrix add/subtract datapath. It accepts one command via a start/busy/done handshake and latches the operands, opcode and size. It drives the datapath for one settle cycle, captures the result and overflow, then writes the active elements back one byte per cycle through a simple memory write port.

Parameters:
ELEM_W, 8, element width in bits
MAX_ELEMS, 25, element slots in a packed matrix (5x5)
ADDR_W, 8, write-back address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  command request, sampled only in IDLE
opcode  in  2  00=ADD, 01=SUB, 10/11=illegal
matrix_size  in  2  00=2x2, 01=3x3, 10=4x4, 11=5x5
matrix_A  in  200  operand A, element j at [j*8 +: 8]
matrix_B  in  200  operand B, same packing
dst_base  in  ADDR_W  write-back base address
dp_matrix_A  out  200  latched A to datapath
dp_matrix_B  out  200  latched B to datapath
dp_size  out  2  latched size to datapath
dp_op_sel  out  2  one-hot: [0]=add enable, [1]=sub enable; 00 when idle
dp_result  in  200  datapath result, same packing
dp_overflow  in  1  datapath overflow flag
wr_en  out  1  write strobe, one element per cycle
wr_addr  out  ADDR_W  write address
wr_data  out  ELEM_W  write data
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
overflow_flag  out  1  captured overflow of the last command
error  out  1  one-cycle pulse, coincident with done, on an illegal opcode

Behaviour:
- Reset (asynchronous, active-high) drives all outputs and registers to 0 and puts the FSM in IDLE. This applies mid-command: no further writes, no done pulse.
- All outputs come from registers or state decode. There is no combinational path from any input to any output.
- N (active elements) = 4/9/16/25 for size 00/01/10/11, decoded from the latched size.
- States: IDLE, EXEC, WRITE, DONE, ERR.
- IDLE, start=1 with a legal opcode (edge E0):
  - Latch A, B, size, opcode and dst_base.
  - Clear overflow_flag.
  - Set dp_op_sel and go to EXEC.
- IDLE, start=1 with an illegal opcode: go to ERR. Operands are not latched and no writes occur.
- EXEC (1 cycle): the datapath settles. At the exit edge:
  - Register dp_result into the result buffer.
  - Register dp_overflow into overflow_flag.
  - Clear idx to 0, clear dp_op_sel, go to WRITE.
- WRITE (N cycles), each cycle:
  - wr_en=1, wr_addr=dst_base+idx (mod 2^ADDR_W), wr_data=result[idx*8 +: 8].
  - idx increments each cycle. At idx==N-1 the next state is DONE.
  - Elements are written in packed index order 0..N-1. Addresses are contiguous with no 5-wide row stride.
- DONE (1 cycle): done=1, then IDLE.
- ERR (1 cycle): done=1 and error=1, then IDLE. overflow_flag is cleared.
- Latency: done is high in the (N+2)th cycle after E0, i.e. 6 cycles for 2x2 and 27 for 5x5. start is accepted again in the cycle after done.
- start while busy is ignored; latched operands are unaffected by input changes during a command.
- overflow_flag holds its value after done until the next accepted start or reset.
- wr_en is 0 in every state except WRITE; wr_addr and wr_data are don't-care when wr_en=0 but are held stable.

Test Plan:
1. SUB, size 00:
   - Stimulus: A elements {10,20,30,40}, B {3,5,7,9}, dst_base=0x10.
   - Response: writes 7@0x10, 15@0x11, 23@0x12, 31@0x13; done 6 cycles after start; overflow_flag=0.
2. ADD, size 11, every element A=0x70, B=0x20:
   - Response: 25 writes of 0x90 to 0x00..0x18; overflow_flag=1; done at cycle 27.
3. opcode=10:
   - Response: ERR for one cycle with done=1 and error=1; no wr_en; busy high for exactly 1 cycle.
4. start pulsed again, with different operands, during WRITE of a 3x3 command:
   - Response: ignored; the original 9 elements are written; exactly one done pulse.
5. reset asserted after the 2nd write of a 4x4 command:
   - Response: outputs immediately 0; no further writes; no done; a subsequent start runs normally.
6. dst_base=0xFE, size 00:
   - Response: wr_addr sequence 0xFE, 0xFF, 0x00, 0x01.
